retire_ctrl: RTL and testbench

Commit-side controller for the reorder buffer. It consumes the ROB's dual commit slots and maintains the retirement (architectural) register map. For each retired destination it releases the superseded physical register to the freelist. On a committed exception it runs the recovery sequence: flush the ROB, then replay the retirement map into the frontend rename table while dispatch is stalled.

---
 rtl/core_pkg.sv | 19 +
 rtl/retire_map.sv | 51 +++++
 rtl/retire_ctrl.sv | 162 ++++++++++++++++
 tb/tb_retire_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants used by the commit-side retirement logic.
package core_pkg;

    localparam int unsigned ISSUE_WIDTH = 2;
    localparam int unsigned ROB_ENTRIES = 32;
    localparam int unsigned PREG_W      = 6;

    typedef logic [PREG_W-1:0] preg_tag_t;

    // Architectural XZR: never mapped, never freed.
    localparam int unsigned ZERO_REG = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        RESTORE = 2'd2
    } retire_state_t;

endpackage

// File: rtl/retire_map.sv
// Retirement (architectural) register map: arch index -> committed physical tag.
// Reads return the pre-write contents so the caller sees the superseded tags.
module retire_map
    import core_pkg::*;
#(
    parameter int unsigned ARCH_REGS = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic      [ISSUE_WIDTH-1:0]         wr_en,
    input  logic      [ISSUE_WIDTH-1:0][4:0]    wr_arch,
    input  preg_tag_t [ISSUE_WIDTH-1:0]         wr_phys,
    input  logic      [ISSUE_WIDTH-1:0][4:0]    rd_arch,
    output preg_tag_t [ISSUE_WIDTH-1:0]         rd_phys,
    input  logic      [4:0]                     rs_arch,
    output preg_tag_t                           rs_phys
);

    preg_tag_t rmap_q [ARCH_REGS];
    preg_tag_t rmap_d [ARCH_REGS];

    // Apply slot writes in order so the highest slot wins on a shared index.
    always_comb begin
        rmap_d = rmap_q;
        for (int unsigned j = 0; j < ISSUE_WIDTH; j++) begin
            if (wr_en[j]) begin
                rmap_d[wr_arch[j]] = wr_phys[j];
            end
        end
    end

    // Map storage, reset to the identity mapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                rmap_q[i] <= preg_tag_t'(i);
            end
        end else begin
            rmap_q <= rmap_d;
        end
    end

    // Read-before-write ports for free tags plus the recovery replay port.
    always_comb begin
        for (int unsigned j = 0; j < ISSUE_WIDTH; j++) begin
            rd_phys[j] = rmap_q[rd_arch[j]];
        end
        rs_phys = rmap_q[rs_arch];
    end

endmodule

// File: rtl/retire_ctrl.sv
// Commit-side controller: retires ROB commit slots into the retirement map,
// frees superseded physical registers, and sequences exception recovery
// (ROB flush, then replay of the retirement map into the frontend RAT).
module retire_ctrl
    import core_pkg::*;
#(
    parameter int unsigned ROB_SIZE  = core_pkg::ROB_ENTRIES,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned ZERO_REG  = core_pkg::ZERO_REG
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic      [ISSUE_WIDTH-1:0]         commit_valid,
    input  logic      [ISSUE_WIDTH-1:0][4:0]    commit_arch_rd,
    input  preg_tag_t [ISSUE_WIDTH-1:0]         commit_phys_rd,
    input  logic      [ISSUE_WIDTH-1:0]         commit_exception,
    output logic      [ISSUE_WIDTH-1:0]         free_en,
    output preg_tag_t [ISSUE_WIDTH-1:0]         free_tag,
    output logic                                rob_flush_en,
    output logic      [$clog2(ROB_SIZE)-1:0]    rob_flush_ptr,
    output logic                                restore_en,
    output logic      [4:0]                     restore_arch,
    output preg_tag_t                           restore_phys,
    output logic                                freelist_rebuild,
    output logic                                stall_dispatch,
    output logic                                trap_req,
    output logic                                recovery_done
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);
    localparam logic [4:0] LAST_IDX = 5'(ARCH_REGS - 1);

    retire_state_t state_q, state_d;
    logic [4:0]    idx_q, idx_d;

    logic      [ISSUE_WIDTH-1:0] map_we;
    preg_tag_t [ISSUE_WIDTH-1:0] map_old;
    preg_tag_t                   rs_phys;
    logic                        trap;

    logic      [ISSUE_WIDTH-1:0] free_en_q, free_en_d;
    preg_tag_t [ISSUE_WIDTH-1:0] free_tag_q, free_tag_d;
    logic                        flush_q, flush_d;
    logic                        restore_en_q, restore_en_d;
    logic      [4:0]             restore_arch_q, restore_arch_d;
    preg_tag_t                   restore_phys_q, restore_phys_d;
    logic                        stall_q, stall_d;
    logic                        trap_q, trap_d;
    logic                        done_q, done_d;

    retire_map #(
        .ARCH_REGS (ARCH_REGS)
    ) u_map (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (map_we),
        .wr_arch (commit_arch_rd),
        .wr_phys (commit_phys_rd),
        .rd_arch (commit_arch_rd),
        .rd_phys (map_old),
        .rs_arch (idx_d),
        .rs_phys (rs_phys)
    );

    // Slot gating: retire in order until the first excepting slot; a lower
    // slot writing the same arch reg supplies the free tag for a higher one.
    always_comb begin
        map_we     = '0;
        free_tag_d = '0;
        trap       = 1'b0;
        for (int unsigned j = 0; j < ISSUE_WIDTH; j++) begin
            if (state_q == IDLE && commit_valid[j] && !trap) begin
                if (commit_exception[j]) begin
                    trap = 1'b1;
                end else if (commit_arch_rd[j] != ZERO_IDX) begin
                    map_we[j]     = 1'b1;
                    free_tag_d[j] = map_old[j];
                    for (int unsigned k = 0; k < j; k++) begin
                        if (map_we[k] && commit_arch_rd[k] == commit_arch_rd[j]) begin
                            free_tag_d[j] = commit_phys_rd[k];
                        end
                    end
                end
            end
        end
        free_en_d = map_we;
    end

    // Recovery FSM next state and replay index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (trap) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = RESTORE;
                idx_d   = '0;
            end
            RESTORE: begin
                if (idx_q == LAST_IDX) state_d = IDLE;
                else                   idx_d   = idx_q + 5'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up
    // with the cycle the FSM occupies that state.
    always_comb begin
        trap_d         = trap;
        flush_d        = (state_d == FLUSH);
        restore_en_d   = (state_d == RESTORE);
        restore_arch_d = restore_en_d ? idx_d : '0;
        restore_phys_d = restore_en_d ? rs_phys : '0;
        done_d         = (state_d == RESTORE) && (idx_d == LAST_IDX);
        stall_d        = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            free_en_q      <= '0;
            free_tag_q     <= '0;
            flush_q        <= 1'b0;
            restore_en_q   <= 1'b0;
            restore_arch_q <= '0;
            restore_phys_q <= '0;
            stall_q        <= 1'b0;
            trap_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            free_en_q      <= free_en_d;
            free_tag_q     <= free_tag_d;
            flush_q        <= flush_d;
            restore_en_q   <= restore_en_d;
            restore_arch_q <= restore_arch_d;
            restore_phys_q <= restore_phys_d;
            stall_q        <= stall_d;
            trap_q         <= trap_d;
            done_q         <= done_d;
        end
    end

    assign free_en          = free_en_q;
    assign free_tag         = free_tag_q;
    assign rob_flush_en     = flush_q;
    assign freelist_rebuild = flush_q;
    assign rob_flush_ptr    = '0;
    assign restore_en       = restore_en_q;
    assign restore_arch     = restore_arch_q;
    assign restore_phys     = restore_phys_q;
    assign stall_dispatch   = stall_q;
    assign trap_req         = trap_q;
    assign recovery_done    = done_q;

endmodule

// File: tb/tb_retire_ctrl.sv
// Scoreboard bench for retire_ctrl: the driver computes expected frees and
// restore writes from a simple architectural-map model; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_retire_ctrl;
    import core_pkg::*;

    localparam int NREG = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic      [ISSUE_WIDTH-1:0]      commit_valid     = '0;
    logic      [ISSUE_WIDTH-1:0][4:0] commit_arch_rd   = '0;
    preg_tag_t [ISSUE_WIDTH-1:0]      commit_phys_rd   = '0;
    logic      [ISSUE_WIDTH-1:0]      commit_exception = '0;

    logic      [ISSUE_WIDTH-1:0]      free_en;
    preg_tag_t [ISSUE_WIDTH-1:0]      free_tag;
    logic                             rob_flush_en;
    logic      [4:0]                  rob_flush_ptr;
    logic                             restore_en;
    logic      [4:0]                  restore_arch;
    preg_tag_t                        restore_phys;
    logic                             freelist_rebuild;
    logic                             stall_dispatch;
    logic                             trap_req;
    logic                             recovery_done;

    retire_ctrl #(
        .ROB_SIZE  (32),
        .ARCH_REGS (NREG),
        .ZERO_REG  (31)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .commit_valid     (commit_valid),
        .commit_arch_rd   (commit_arch_rd),
        .commit_phys_rd   (commit_phys_rd),
        .commit_exception (commit_exception),
        .free_en          (free_en),
        .free_tag         (free_tag),
        .rob_flush_en     (rob_flush_en),
        .rob_flush_ptr    (rob_flush_ptr),
        .restore_en       (restore_en),
        .restore_arch     (restore_arch),
        .restore_phys     (restore_phys),
        .freelist_rebuild (freelist_rebuild),
        .stall_dispatch   (stall_dispatch),
        .trap_req         (trap_req),
        .recovery_done    (recovery_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [1:0] en; int t0; int t1; } free_rec_t;
    typedef struct { int cyc; int arch; int phys; } rest_rec_t;

    free_rec_t free_q[$];
    rest_rec_t rest_q[$];
    free_rec_t fr;
    rest_rec_t rr;

    int mdl [NREG];
    int exc_cyc  = -1000;
    int exp_trap = -1000;
    bit mon_en   = 1'b0;
    int checks   = 0;
    int errors   = 0;
    logic [5:0] ctl_act, ctl_exp;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mdl[i] = i;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_free_en"},      free_en, 0);
        chk({pfx, "_free_tag"},     free_tag, 0);
        chk({pfx, "_rob_flush_en"}, rob_flush_en, 0);
        chk({pfx, "_flush_ptr"},    rob_flush_ptr, 0);
        chk({pfx, "_restore_en"},   restore_en, 0);
        chk({pfx, "_restore_arch"}, restore_arch, 0);
        chk({pfx, "_restore_phys"}, restore_phys, 0);
        chk({pfx, "_rebuild"},      freelist_rebuild, 0);
        chk({pfx, "_stall"},        stall_dispatch, 0);
        chk({pfx, "_trap"},         trap_req, 0);
        chk({pfx, "_done"},         recovery_done, 0);
    endtask

    // Drive one cycle of commit inputs and record the expected response.
    task automatic drive(input logic [1:0] v, input logic [1:0] e,
                         input int r0, input int p0, input int r1, input int p1);
        int c;
        int r [2];
        int p [2];
        int ft [2];
        logic [1:0] fen;
        bit trap;
        c = cyc;
        r = '{r0, r1};
        p = '{p0, p1};
        ft = '{0, 0};
        fen = '0;
        trap = 1'b0;
        commit_valid        = v;
        commit_exception    = e;
        commit_arch_rd[0]   = 5'(r0);
        commit_arch_rd[1]   = 5'(r1);
        commit_phys_rd[0]   = preg_tag_t'(p0);
        commit_phys_rd[1]   = preg_tag_t'(p1);
        if (!(c >= exc_cyc + 1 && c <= exc_cyc + NREG + 1)) begin
            for (int j = 0; j < 2; j++) begin
                if (!v[j]) continue;
                if (e[j]) begin
                    trap = 1'b1;
                    break;
                end
                if (r[j] != 31) begin
                    fen[j] = 1'b1;
                    ft[j]  = mdl[r[j]];
                    mdl[r[j]] = p[j];
                end
            end
            if (fen != 2'b00) free_q.push_back('{c + 1, fen, ft[0], ft[1]});
            if (trap) begin
                exc_cyc  = c;
                exp_trap = c + 1;
                for (int i = 0; i < NREG; i++) rest_q.push_back('{c + 2 + i, i, mdl[i]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    function automatic int pick_rd();
        int k;
        k = int'($urandom_range(0, 8));
        return (k == 8) ? 31 : k;
    endfunction

    // Monitor: pops expected frees/restores as the DUT presents them.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            ctl_act = {trap_req, rob_flush_en, freelist_rebuild, recovery_done,
                       stall_dispatch, |rob_flush_ptr};
            ctl_exp = {cyc == exp_trap, cyc == exp_trap, cyc == exp_trap,
                       cyc == exp_trap + NREG,
                       (cyc >= exp_trap) && (cyc <= exp_trap + NREG), 1'b0};
            chk("ctrl_vec", ctl_act, ctl_exp);

            while (free_q.size() > 0 && free_q[0].cyc < cyc) begin
                chk("free_missing_cyc", cyc, free_q[0].cyc);
                fr = free_q.pop_front();
            end
            if (free_en != 2'b00) begin
                if (free_q.size() == 0) begin
                    chk("free_unexpected", free_en, 0);
                end else begin
                    fr = free_q.pop_front();
                    chk("free_cycle", cyc, fr.cyc);
                    chk("free_en", free_en, fr.en);
                    chk("free_tag0", free_en[0] ? int'(free_tag[0]) : 0, fr.t0);
                    chk("free_tag1", free_en[1] ? int'(free_tag[1]) : 0, fr.t1);
                end
            end

            while (rest_q.size() > 0 && rest_q[0].cyc < cyc) begin
                chk("restore_missing_cyc", cyc, rest_q[0].cyc);
                rr = rest_q.pop_front();
            end
            if (restore_en) begin
                if (rest_q.size() == 0) begin
                    chk("restore_unexpected", restore_en, 0);
                end else begin
                    rr = rest_q.pop_front();
                    chk("restore_cycle", cyc, rr.cyc);
                    chk("restore_arch", restore_arch, rr.arch);
                    chk("restore_phys", restore_phys, rr.phys);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Recovery straight out of reset replays the identity map.
        drive(2'b01, 2'b01, 4, 12, 0, 0);
        idle(40);

        // Plain dual retire, same-rd bypass, and XZR destinations.
        drive(2'b11, 2'b00, 3, 40, 5, 41);
        drive(2'b11, 2'b00, 7, 50, 7, 51);
        drive(2'b01, 2'b00, 31, 60, 0, 0);
        drive(2'b11, 2'b00, 31, 61, 31, 62);
        idle(2);

        // Slot1 exception: slot0 retires, recovery replays 3/5/7/2 updates,
        // and commits arriving during recovery are dropped.
        drive(2'b11, 2'b10, 2, 33, 9, 44);
        for (int i = 0; i < NREG + 1; i++)
            drive(2'b11, 2'(i & 1), pick_rd(), int'($urandom_range(0, 63)),
                  pick_rd(), int'($urandom_range(0, 63)));
        idle(4);

        // Reset while replaying index 10.
        drive(2'b01, 2'b01, 0, 0, 0, 0);
        while (cyc < exc_cyc + 12) drive(2'b00, 2'b00, 0, 0, 0, 0);
        chk("pre_reset_restore_en", restore_en, 1);
        chk("pre_reset_restore_arch", restore_arch, 10);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_zero("midrst");
        free_q.delete();
        rest_q.delete();
        model_reset();
        exc_cyc  = -1000;
        exp_trap = -1000;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        drive(2'b01, 2'b01, 0, 0, 0, 0);
        idle(40);

        // Randomized traffic with occasional exceptions.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] v, e;
            v = 2'($urandom);
            e = {($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0)};
            drive(v, e, pick_rd(), int'($urandom_range(0, 63)),
                  pick_rd(), int'($urandom_range(0, 63)));
        end
        idle(40);

        chk("free_q_left", free_q.size(), 0);
        chk("rest_q_left", rest_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
